// File: rtl/mm_bus_master.sv
// mm_bus_master
//   Single-outstanding initiator for the 64-bit configuration memory-map bus.
//   It takes one read or write command at a time and drives a one-cycle
//   strobe toward the address decoder. For a read, it waits a bounded number
//   of cycles for read data. It then returns exactly one response.
//
// Ports
//   clk, rst             sole clock; synchronous active-high reset
//   cmd_valid/ready      command handshake (cmd_wr, cmd_addr, cmd_wdata)
//   oMM_WR_EN/RD_EN      one-cycle bus strobes
//   oMM_ADDR/WR_DATA     bus address and write data, held until next accept
//   iMM_RD_DATA(_V)      read data and one-cycle valid from the decoder
//   rsp_valid/ready      response handshake (rsp_wr, rsp_err, rsp_data)
//   stray_cnt            saturating count of read-valid pulses outside RD_WAIT
//
// DATA_W must be at least ADDR_W+32 so the timeout pattern fits.
// TIMEOUT must be in the range 4..65535.
module mm_bus_master #(
  parameter int ADDR_W  = 17,
  parameter int DATA_W  = 64,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_wr,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              oMM_WR_EN,
  output logic              oMM_RD_EN,
  output logic [ADDR_W-1:0] oMM_ADDR,
  output logic [DATA_W-1:0] oMM_WR_DATA,
  input  logic [DATA_W-1:0] iMM_RD_DATA,
  input  logic              iMM_RD_DATA_V,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_wr,
  output logic              rsp_err,
  output logic [DATA_W-1:0] rsp_data,
  output logic [15:0]       stray_cnt
);
  localparam logic [15:0] TMO = 16'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, RD_WAIT, RSP} state_t;

  state_t            state, state_nxt;
  logic [15:0]       timer, timer_nxt;
  logic              accept, rd_hit, rd_tmo, rsp_done;
  logic [DATA_W-1:0] tmo_pat;

  logic              wr_en_nxt, rd_en_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [DATA_W-1:0] wdata_nxt;
  logic              rsp_valid_nxt, rsp_wr_nxt, rsp_err_nxt;
  logic [DATA_W-1:0] rsp_data_nxt;
  logic [15:0]       stray_nxt;

  assign cmd_ready = (state == IDLE) && !rst;
  assign accept    = cmd_valid && cmd_ready;
  // Valid data wins over a timeout that expires in the same cycle.
  assign rd_hit    = (state == RD_WAIT) && iMM_RD_DATA_V;
  assign rd_tmo    = (state == RD_WAIT) && !iMM_RD_DATA_V && (timer == TMO);
  assign rsp_done  = (state == RSP) && rsp_ready;

  // Error payload: marker in the top word, faulting address in the low bits.
  always_comb begin
    tmo_pat                   = '0;
    tmo_pat[DATA_W-1 -: 32]   = 32'hDEAD_BEEF;
    tmo_pat[ADDR_W-1:0]       = oMM_ADDR;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = cmd_wr ? RSP : RD_WAIT;
      RD_WAIT: if (rd_hit || rd_tmo) state_nxt = RSP;
      RSP:     if (rsp_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next values of the registered outputs
  always_comb begin
    wr_en_nxt     = accept && cmd_wr;
    rd_en_nxt     = accept && !cmd_wr;
    addr_nxt      = oMM_ADDR;
    wdata_nxt     = oMM_WR_DATA;
    rsp_valid_nxt = rsp_valid;
    rsp_wr_nxt    = rsp_wr;
    rsp_err_nxt   = rsp_err;
    rsp_data_nxt  = rsp_data;
    timer_nxt     = timer;
    stray_nxt     = stray_cnt;
    case (state)
      IDLE: if (accept) begin
        addr_nxt   = cmd_addr;
        wdata_nxt  = cmd_wdata;
        rsp_wr_nxt = cmd_wr;
        timer_nxt  = '0;
        // Writes are posted: the response goes out alongside the strobe.
        if (cmd_wr) begin
          rsp_valid_nxt = 1'b1;
          rsp_err_nxt   = 1'b0;
          rsp_data_nxt  = '0;
        end
      end
      RD_WAIT: begin
        if (rd_hit) begin
          rsp_valid_nxt = 1'b1;
          rsp_err_nxt   = 1'b0;
          rsp_data_nxt  = iMM_RD_DATA;
        end else if (rd_tmo) begin
          rsp_valid_nxt = 1'b1;
          rsp_err_nxt   = 1'b1;
          rsp_data_nxt  = tmo_pat;
        end else begin
          timer_nxt = timer + 16'd1;
        end
      end
      RSP: if (rsp_done) rsp_valid_nxt = 1'b0;
      default: ;
    endcase
    // Read data outside RD_WAIT, including late data after a timeout, is dropped.
    if (iMM_RD_DATA_V && (state != RD_WAIT) && (stray_cnt != 16'hFFFF))
      stray_nxt = stray_cnt + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      oMM_WR_EN   <= 1'b0;
      oMM_RD_EN   <= 1'b0;
      oMM_ADDR    <= '0;
      oMM_WR_DATA <= '0;
      rsp_valid   <= 1'b0;
      rsp_wr      <= 1'b0;
      rsp_err     <= 1'b0;
      rsp_data    <= '0;
      timer       <= '0;
      stray_cnt   <= '0;
    end else begin
      oMM_WR_EN   <= wr_en_nxt;
      oMM_RD_EN   <= rd_en_nxt;
      oMM_ADDR    <= addr_nxt;
      oMM_WR_DATA <= wdata_nxt;
      rsp_valid   <= rsp_valid_nxt;
      rsp_wr      <= rsp_wr_nxt;
      rsp_err     <= rsp_err_nxt;
      rsp_data    <= rsp_data_nxt;
      timer       <= timer_nxt;
      stray_cnt   <= stray_nxt;
    end
  end
endmodule
